dot_motion: RTL and testbench
=============================

# dot_motion

Parametrised successor to the single-step dot mover: computes the flappy dot's screen position with signed vertical velocity, gravity, edge-triggered flap impulse, floor/ceiling clamping, a configurable update rate and a respawn hold after collision. It sits between the input debouncer and the collision/column logic. It drives the pixel coordinates to the renderer and the column-reset strobe to the pipe generator.

## Interface
- X_W, 8: x coordinate width
- Y_W, 7: y coordinate width
- X_MAX, 160: x value at which the dot wraps to 0
- Y_MAX, 119: lowest legal y (floor); 0 is the ceiling
- Y_START, 59: spawn y
- V_W, 4: signed velocity width (two's complement)
- GRAVITY, 1: velocity increment per step
- FLAP_V, 3: flap sets velocity to −FLAP_V
- V_MAX, 4: downward velocity cap
- STEP_DIV, 4: dot_clk cycles per motion step (≥1)
- RESPAWN_CYC, 8: motion steps held at spawn after collision
- dot_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- up  in  1  flap button, level (synchronised upstream)
- collided  in  1  level, high while dot overlaps a pipe
- keep_moving  in  1  low = freeze motion
- dot_x_cord  out  X_W  dot x
- dot_y_cord  out  Y_W  dot y
- dot_vel  out  V_W  signed vertical velocity (positive = down)
- reset_col  out  1  active-low one-cycle strobe: columns reset
- lap_count  out  8  completed screen traversals, wraps 255→0
- respawning  out  1  high in RESPAWN state

## Operation
- Reset (async): state READY, x=0, y=Y_START, vel=0, reset_col=1, lap_count=0, prescaler=0, flap latch=0, respawning=0.
- Prescaler counts 0..STEP_DIV−1 every cycle. A step occurs on the cycle with count=STEP_DIV−1. It counts in all states and is cleared only by reset.
- Flap latch: set on an up rising edge (up & ~up_q). Cleared on the step that consumes it, or on entering RESPAWN.
- READY: position held. On the first flap edge, go to RUN and keep the latch.
- RUN, on a step, in priority order:
  - collided=1: go to RESPAWN; x=0; y=Y_START; vel=0; reset_col=0 for 1 cycle; respawn counter=0.
  - keep_moving=0: go to FREEZE; nothing changes.
  - x==X_MAX: x=0; y and vel unchanged; reset_col=0 for 1 cycle; lap_count+1.
  - Otherwise: x=x+1. vel_n = −FLAP_V if the latch is set, else min(vel+GRAVITY, V_MAX). y_n = y+vel_n is computed at Y_W+2 signed width and clamped to [0, Y_MAX]. If clamped, vel=0.
- A collision that occurs between steps is acted on at the next step. It is not latched; the level must still be present at the step.
- FREEZE: all outputs held, reset_col=1. Return to RUN on the first step with keep_moving=1. collided in FREEZE is ignored.
- RESPAWN: position held at spawn, reset_col=1, respawning=1, flap edges ignored. Each step increments the counter. When counter==RESPAWN_CYC−1, go to READY on that step.
- reset_col is 1 at all times except the single strobe cycle.

## Timing
- Outputs are registered. A step's effects are visible the cycle after the step cycle.
- With STEP_DIV=1, every cycle is a step. Latency from an up edge to a vel change is 1 step when the edge precedes or coincides with the step cycle.
- Reset asserted mid-operation returns every register to its reset value immediately, with no pending strobe.
- A wrap and a flap in the same step: the wrap wins and the latch persists to the next step.

## Test plan
- Reset with defaults, flap once, hold up=0 with STEP_DIV=1: y sequence 59,56,54,53,53,54,56,59,63,67…; vel −3,−2,−1,0,1,2,3,4,4.
- Floor clamp: hold y near 119 with vel=4 → y stops at 119, vel=0, no overflow. Ceiling: repeated flaps → y=0, vel=0.
- Wrap: run to x=160 → next step x=0, reset_col low exactly 1 cycle, lap_count=1.
- Collision at x=40 → x=0, y=59, one reset_col pulse, respawning=1 for 8 steps, then READY; a flap during RESPAWN is ignored.
- keep_moving=0 for 10 steps mid-run → all outputs constant. Then keep_moving=1 → motion resumes from the same x, y and vel.
- STEP_DIV=4: x advances once per 4 cycles. Assert reset async mid-flight → x=0, y=59, lap_count=0 without waiting for a clock edge.

Source files
------------

// File: rtl/dot_motion.sv
// Flappy dot position engine: prescaled motion steps with gravity, flap impulse,
// floor/ceiling clamping, x wrap with lap counting and a timed respawn hold.
module dot_motion #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = 160,
    parameter int Y_MAX       = 119,
    parameter int Y_START     = 59,
    parameter int V_W         = 4,
    parameter int GRAVITY     = 1,
    parameter int FLAP_V      = 3,
    parameter int V_MAX       = 4,
    parameter int STEP_DIV    = 4,
    parameter int RESPAWN_CYC = 8
) (
    input  logic           dot_clk,
    input  logic           reset,
    input  logic           up,
    input  logic           collided,
    input  logic           keep_moving,
    output logic [X_W-1:0] dot_x_cord,
    output logic [Y_W-1:0] dot_y_cord,
    output logic [V_W-1:0] dot_vel,
    output logic           reset_col,
    output logic [7:0]     lap_count,
    output logic           respawning
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int RW = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;

    localparam logic [PW-1:0]         STEP_LAST = PW'(STEP_DIV - 1);
    localparam logic [RW-1:0]         RESP_LAST = RW'(RESPAWN_CYC - 1);
    localparam logic [X_W-1:0]        X_LAST    = X_W'(X_MAX);
    localparam logic [Y_W-1:0]        Y_SPAWN   = Y_W'(Y_START);
    localparam logic [Y_W-1:0]        Y_FLOOR   = Y_W'(Y_MAX);
    localparam logic [V_W-1:0]        FLAP_VEL  = V_W'(-FLAP_V);
    localparam logic signed [V_W+1:0] GRAV_S    = (V_W+2)'(GRAVITY);
    localparam logic signed [V_W+1:0] V_MAX_S   = (V_W+2)'(V_MAX);
    localparam logic signed [Y_W+1:0] Y_MAX_S   = (Y_W+2)'(Y_MAX);

    typedef enum logic [1:0] {S_READY, S_RUN, S_FREEZE, S_RESPAWN} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [RW-1:0]   resp_cnt;
    logic            up_q;
    logic            flap_latch;

    logic                   step;
    logic                   flap_edge;
    logic                   flap_pending;
    logic signed [V_W+1:0]  vel_grav;
    logic [V_W-1:0]         vel_next;
    logic signed [Y_W+1:0]  y_sum;
    logic [Y_W-1:0]         y_step;
    logic [V_W-1:0]         vel_step;

    // Candidate motion for the next step; only committed on a RUN step.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        step         = (presc == STEP_LAST);
        flap_edge    = up & ~up_q;
        flap_pending = flap_latch | flap_edge;
        vel_grav     = {{2{dot_vel[V_W-1]}}, dot_vel} + GRAV_S;
        if (flap_pending)
            vel_next = FLAP_VEL;
        else if (vel_grav > V_MAX_S)
            vel_next = V_MAX_S[V_W-1:0];
        else
            vel_next = vel_grav[V_W-1:0];
        y_sum    = $signed({2'b00, dot_y_cord}) + $signed({{(Y_W+2-V_W){vel_next[V_W-1]}}, vel_next});
        y_step   = y_sum[Y_W-1:0];
        vel_step = vel_next;
        if (y_sum[Y_W+1]) begin
            y_step   = '0;
            vel_step = '0;
        end else if (y_sum > Y_MAX_S) begin
            y_step   = Y_FLOOR;
            vel_step = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            state      <= S_READY;
            presc      <= '0;
            resp_cnt   <= '0;
            up_q       <= 1'b0;
            flap_latch <= 1'b0;
            dot_x_cord <= '0;
            dot_y_cord <= Y_SPAWN;
            dot_vel    <= '0;
            reset_col  <= 1'b1;
            lap_count  <= '0;
            respawning <= 1'b0;
        end else begin
            up_q      <= up;
            presc     <= step ? '0 : presc + PW'(1);
            reset_col <= 1'b1;
            if (flap_edge)
                flap_latch <= 1'b1;

            case (state)
                S_READY: begin
                    if (flap_edge)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (step) begin
                        if (collided) begin
                            state      <= S_RESPAWN;
                            dot_x_cord <= '0;
                            dot_y_cord <= Y_SPAWN;
                            dot_vel    <= '0;
                            reset_col  <= 1'b0;
                            resp_cnt   <= '0;
                            flap_latch <= 1'b0;
                            respawning <= 1'b1;
                        end else if (!keep_moving) begin
                            state <= S_FREEZE;
                        end else if (dot_x_cord == X_LAST) begin
                            // Wrap outranks a pending flap, which stays latched.
                            dot_x_cord <= '0;
                            reset_col  <= 1'b0;
                            lap_count  <= lap_count + 8'd1;
                        end else begin
                            dot_x_cord <= dot_x_cord + X_W'(1);
                            dot_y_cord <= y_step;
                            dot_vel    <= vel_step;
                            flap_latch <= 1'b0;
                        end
                    end
                end
                S_FREEZE: begin
                    if (step && keep_moving)
                        state <= S_RUN;
                end
                S_RESPAWN: begin
                    flap_latch <= 1'b0;
                    if (step) begin
                        if (resp_cnt == RESP_LAST) begin
                            state      <= S_READY;
                            respawning <= 1'b0;
                        end else begin
                            resp_cnt <= resp_cnt + RW'(1);
                        end
                    end
                end
                default: state <= S_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_motion.sv
// Bench for dot_motion: two instances (every-cycle and divide-by-4 steps) checked each
// cycle against a behavioural model, plus directed literal expectations.
module tb_dot_motion;

    localparam int M_READY   = 0;
    localparam int M_RUN     = 1;
    localparam int M_FREEZE  = 2;
    localparam int M_RESPAWN = 3;

    typedef struct {
        int mode;
        int cyc;
        bit upq;
        bit latch;
        int x;
        int y;
        int vel;
        int lap;
        bit rcol;
        int rleft;
    } mdl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic up, collided, keep_moving;

    logic [7:0] x1, x4, lap1, lap4;
    logic [6:0] y1, y4;
    logic [3:0] v1, v4;
    logic       rc1, rc4, rsp1, rsp4;

    int tests = 0;
    int fails = 0;

    mdl_t m1, m4;

    int ys[10] = '{59, 56, 54, 53, 53, 54, 56, 59, 63, 67};
    int vs[10] = '{0, -3, -2, -1, 0, 1, 2, 3, 4, 4};

    dot_motion #(.STEP_DIV(1)) u_dut1 (
        .dot_clk(clk), .reset(reset), .up(up), .collided(collided), .keep_moving(keep_moving),
        .dot_x_cord(x1), .dot_y_cord(y1), .dot_vel(v1), .reset_col(rc1),
        .lap_count(lap1), .respawning(rsp1)
    );

    dot_motion #(.STEP_DIV(4)) u_dut4 (
        .dot_clk(clk), .reset(reset), .up(up), .collided(collided), .keep_moving(keep_moving),
        .dot_x_cord(x4), .dot_y_cord(y4), .dot_vel(v4), .reset_col(rc4),
        .lap_count(lap4), .respawning(rsp4)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.mode  = M_READY;
        r.cyc   = 0;
        r.upq   = 1'b0;
        r.latch = 1'b0;
        r.x     = 0;
        r.y     = 59;
        r.vel   = 0;
        r.lap   = 0;
        r.rcol  = 1'b1;
        r.rleft = 0;
        return r;
    endfunction

    // One clock of game behaviour: steps every div cycles since reset.
    function automatic mdl_t mdl_next(mdl_t m, int div, bit u, bit c, bit k);
        mdl_t n;
        bit   flap;
        bit   stp;
        int   v;
        int   ny;
        n      = m;
        flap   = u && !m.upq;
        stp    = ((m.cyc + 1) % div) == 0;
        n.cyc  = m.cyc + 1;
        n.upq  = u;
        n.rcol = 1'b1;
        if (flap && m.mode != M_RESPAWN) n.latch = 1'b1;
        case (m.mode)
            M_READY: if (flap) n.mode = M_RUN;
            M_RUN: if (stp) begin
                if (c) begin
                    n.mode = M_RESPAWN; n.x = 0; n.y = 59; n.vel = 0;
                    n.rcol = 1'b0; n.rleft = 8; n.latch = 1'b0;
                end else if (!k) begin
                    n.mode = M_FREEZE;
                end else if (m.x == 160) begin
                    n.x = 0; n.rcol = 1'b0; n.lap = (m.lap + 1) % 256;
                end else begin
                    v  = (m.latch || flap) ? -3 : ((m.vel + 1 > 4) ? 4 : m.vel + 1);
                    ny = m.y + v;
                    if (ny < 0) begin ny = 0; v = 0; end
                    else if (ny > 119) begin ny = 119; v = 0; end
                    n.x = m.x + 1; n.y = ny; n.vel = v; n.latch = 1'b0;
                end
            end
            M_FREEZE: if (stp && k) n.mode = M_RUN;
            default: begin
                n.latch = 1'b0;
                if (stp) begin
                    n.rleft = m.rleft - 1;
                    if (n.rleft == 0) n.mode = M_READY;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m1 <= mdl_reset();
            m4 <= mdl_reset();
        end else begin
            m1 <= mdl_next(m1, 1, up, collided, keep_moving);
            m4 <= mdl_next(m4, 4, up, collided, keep_moving);
        end
    end

    task automatic cmp(input string tag, input mdl_t m, input int x, input int y, input int v,
                       input int rc, input int lap, input int rsp);
        check({tag, ".x"}, x, m.x);
        check({tag, ".y"}, y, m.y);
        check({tag, ".vel"}, v, m.vel);
        check({tag, ".reset_col"}, rc, int'(m.rcol));
        check({tag, ".lap"}, lap, m.lap);
        check({tag, ".respawning"}, rsp, int'(m.mode == M_RESPAWN));
    endtask

    always @(negedge clk) begin
        cmp("d1", m1, x1, y1, int'($signed(v1)), rc1, lap1, rsp1);
        cmp("d4", m4, x4, y4, int'($signed(v4)), rc4, lap4, rsp4);
    end

    task automatic wait_x(input int target, input int budget);
        int n = 0;
        while (int'(x1) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reach_x", x1, target);
    endtask

    initial begin
        int n;
        up = 1'b0;
        collided = 1'b0;
        keep_moving = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_x", x1, 0);
        check("rst_y", y1, 59);
        check("rst_vel", int'($signed(v1)), 0);
        check("rst_rc", rc1, 1);
        check("rst_lap", lap1, 0);
        check("rst_rsp", rsp1, 0);

        // Single flap, then free fall
        reset = 1'b0;
        up = 1'b1;
        @(negedge clk);
        up = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("arc_y", y1, ys[i]);
            check("arc_vel", int'($signed(v1)), vs[i]);
        end

        repeat (20) @(negedge clk);
        check("floor_y", y1, 119);
        check("floor_vel", int'($signed(v1)), 0);

        // Flap every other step until pinned at the ceiling
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); up = 1'b1;
            @(negedge clk); up = 1'b0;
        end
        check("ceil_y", y1, 0);
        check("ceil_vel", int'($signed(v1)), 0);

        // Wrap coinciding with a flap edge
        wait_x(160, 200);
        up = 1'b1;
        @(negedge clk);
        up = 1'b0;
        check("wrap_x", x1, 0);
        check("wrap_rc", rc1, 0);
        check("wrap_lap", lap1, 1);
        check("wrap_vel", int'($signed(v1)), 0);
        @(negedge clk);
        check("postwrap_x", x1, 1);
        check("postwrap_rc", rc1, 1);
        check("postwrap_vel", int'($signed(v1)), -3);
        check("postwrap_y", y1, 116);

        // Freeze with a collision pulse that must be ignored
        keep_moving = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            collided = (i >= 2 && i < 5);
            check("frz_x", x1, 1);
            check("frz_y", y1, 116);
            check("frz_vel", int'($signed(v1)), -3);
            check("frz_rc", rc1, 1);
        end
        keep_moving = 1'b1;
        @(negedge clk);
        check("unfrz_x0", x1, 1);
        @(negedge clk);
        check("unfrz_x", x1, 2);
        check("unfrz_y", y1, 114);
        check("unfrz_vel", int'($signed(v1)), -2);

        // Collision and respawn hold with flap edges during it
        wait_x(40, 100);
        collided = 1'b1;
        @(negedge clk);
        collided = 1'b0;
        check("col_x", x1, 0);
        check("col_y", y1, 59);
        check("col_vel", int'($signed(v1)), 0);
        check("col_rc", rc1, 0);
        check("col_rsp", rsp1, 1);
        n = 1;
        while (rsp1 == 1'b1 && n < 20) begin
            up = (n < 6) && (n % 2 == 1);
            @(negedge clk);
            if (rsp1) n++;
        end
        up = 1'b0;
        check("resp_len", n, 8);
        repeat (3) @(negedge clk);
        check("ready_x", x1, 0);
        check("ready_y", y1, 59);
        check("ready_rsp", rsp1, 0);
        check("ready_lap", lap1, 1);

        // Asynchronous reset in flight
        up = 1'b1;
        @(negedge clk);
        up = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_x1", x1, 0);
        check("arst_y1", y1, 59);
        check("arst_lap1", lap1, 0);
        check("arst_vel1", int'($signed(v1)), 0);
        check("arst_rc1", rc1, 1);
        check("arst_x4", x4, 0);
        check("arst_y4", y4, 59);

        // Divide-by-4 stepping from a fresh reset
        @(negedge clk);
        reset = 1'b0;
        up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) up = 1'b0;
            check("div4_x", x4, (i + 1) / 4);
            if (i == 3) begin
                check("div4_y", y4, 56);
                check("div4_vel", int'($signed(v4)), -3);
            end
        end

        repeat (4) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
